// File: rtl/peripheral_msi_arb_rr_wb.sv
// ---------------------------------------------------------------------------
// peripheral_msi_arb_rr_wb
// Round-robin Wishbone arbiter: NM masters share one slave port. A grant is
// taken from IDLE, held in BUSY until the slave acks, the granted master
// drops its cycle, or TIMEOUT BUSY cycles elapse (then one ERR cycle).
//
// Ports
//   wbm_clk / wbm_rst        clock, asynchronous active-low reset
//   m_adr/dat/sel/we_i       packed per-master request fields
//   m_cyc_i / m_stb_i        per-master cycle / strobe
//   m_dat_o                  read data broadcast (s_dat_i passthrough)
//   m_ack_o / m_err_o        per-master acknowledge / timeout error
//   s_adr/dat/sel/we_o       muxed request to the slave
//   s_cyc_o / s_stb_o        slave cycle / strobe (BUSY only)
//   s_dat_i / s_ack_i        slave read data / acknowledge
//   gnt_o                    one-hot current grant, zero in IDLE
// ---------------------------------------------------------------------------
module peripheral_msi_arb_rr_wb #(
    parameter int AW      = 32,
    parameter int NM      = 2,
    parameter int TIMEOUT = 256
) (
    input  logic             wbm_clk,
    input  logic             wbm_rst,
    input  logic [NM*AW-1:0] m_adr_i,
    input  logic [NM*32-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    output logic [31:0]      m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [31:0]      s_dat_i,
    input  logic             s_ack_i,
    output logic [NM-1:0]    gnt_o
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [NM-1:0] req;
    logic          rr_found;
    logic [IW-1:0] rr_pick;
    logic [IW-1:0] rr_cand;

    assign req = m_cyc_i & m_stb_i;

    // Search starts just after the last served master so every requester
    // is reached within NM grants.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_q;
        rr_cand  = last_q;
        for (int unsigned k = 1; k <= NM; k++) begin
            rr_cand = IW'((32'(last_q) + k) % NM);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    always_ff @(posedge wbm_clk or negedge wbm_rst) begin
        if (!wbm_rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IW'(NM - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        m_ack_o = '0;
        m_err_o = '0;
        gnt_o   = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    g_d     = rr_pick;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_cyc_o      = 1'b1;
                s_stb_o      = 1'b1;
                gnt_o[g_q]   = 1'b1;
                // Ack wins over abort and over the final timeout cycle.
                if (s_ack_i) begin
                    m_ack_o[g_q] = 1'b1;
                    last_d       = g_q;
                    state_d      = IDLE;
                end else if (!m_cyc_i[g_q]) begin
                    last_d  = g_q;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                gnt_o[g_q]   = 1'b1;
                m_err_o[g_q] = 1'b1;
                last_d       = g_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_adr_o = m_adr_i[g_q*AW +: AW];
    assign s_dat_o = m_dat_i[g_q*32 +: 32];
    assign s_sel_o = m_sel_i[g_q*4 +: 4];
    assign s_we_o  = m_we_i[g_q];
    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_peripheral_msi_arb_rr_wb.sv
module tb_peripheral_msi_arb_rr_wb;
    localparam int AW = 32;
    localparam int NM = 2;
    localparam int TO = 4;

    logic             wbm_clk = 1'b0;
    logic             wbm_rst = 1'b0;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*32-1:0] m_dat_i;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM-1:0]    m_we_i  = '0;
    logic [NM-1:0]    m_cyc_i = '0;
    logic [NM-1:0]    m_stb_i = '0;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic [AW-1:0]    s_adr_o;
    logic [31:0]      s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic             s_cyc_o;
    logic             s_stb_o;
    logic [31:0]      s_dat_i = '0;
    logic             s_ack_i = 1'b0;
    logic [NM-1:0]    gnt_o;

    logic [AW-1:0] adr_a [NM];
    logic [31:0]   dat_a [NM];
    logic [3:0]    sel_a [NM];

    always_comb begin
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        for (int i = 0; i < NM; i++) begin
            m_adr_i[i*AW +: AW] = adr_a[i];
            m_dat_i[i*32 +: 32] = dat_a[i];
            m_sel_i[i*4 +: 4]   = sel_a[i];
        end
    end

    peripheral_msi_arb_rr_wb #(.AW(AW), .NM(NM), .TIMEOUT(TO)) dut (
        .wbm_clk(wbm_clk), .wbm_rst(wbm_rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    always #5 wbm_clk = ~wbm_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: who owns the slave, how long it has held
    // it, whether an error cycle is pending, and who was served last.
    int owner;
    int age;
    int errm;
    int last_m;
    bit in_err;

    task automatic model_reset();
        owner  = -1;
        age    = 0;
        errm   = 0;
        in_err = 1'b0;
        last_m = NM - 1;
    endtask

    // Called just after a negedge with inputs applied; checks outputs,
    // advances the model over the coming posedge, returns at next negedge.
    task automatic tick();
        logic [NM-1:0] e_gnt, e_ack, e_err;
        logic          e_cyc;
        int            c;
        #1;
        e_gnt = '0; e_ack = '0; e_err = '0; e_cyc = 1'b0;
        if (in_err) begin
            e_gnt[errm] = 1'b1;
            e_err[errm] = 1'b1;
        end else if (owner >= 0) begin
            e_cyc        = 1'b1;
            e_gnt[owner] = 1'b1;
            if (s_ack_i) e_ack[owner] = 1'b1;
            check("s_adr", s_adr_o, adr_a[owner]);
            check("s_dat", s_dat_o, dat_a[owner]);
            check("s_sel", s_sel_o, sel_a[owner]);
            check("s_we", s_we_o, m_we_i[owner]);
        end
        check("gnt", gnt_o, e_gnt);
        check("ack", m_ack_o, e_ack);
        check("err", m_err_o, e_err);
        check("s_cyc", s_cyc_o, e_cyc);
        check("s_stb", s_stb_o, e_cyc);
        check("m_dat", m_dat_o, s_dat_i);

        if (in_err) begin
            in_err = 1'b0;
        end else if (owner >= 0) begin
            if (s_ack_i || !m_cyc_i[owner]) begin
                last_m = owner;
                owner  = -1;
            end else if (age + 1 == TO) begin
                in_err = 1'b1;
                errm   = owner;
                last_m = owner;
                owner  = -1;
            end else begin
                age++;
            end
        end else begin
            for (int k = 1; k <= NM; k++) begin
                c = (last_m + k) % NM;
                if (owner < 0 && m_cyc_i[c] && m_stb_i[c]) begin
                    owner = c;
                    age   = 0;
                end
            end
        end
        @(negedge wbm_clk);
    endtask

    task automatic idle_all();
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = 1'b0;
    endtask

    initial begin
        int nack;
        int stb_cnt;
        model_reset();
        for (int i = 0; i < NM; i++) begin
            adr_a[i] = AW'(32'h100 * (i + 1));
            dat_a[i] = 32'hA000_0000 + 32'(i);
            sel_a[i] = 4'hF;
        end

        // Reset state
        m_cyc_i = '1; m_stb_i = '1; s_ack_i = 1'b1;
        @(negedge wbm_clk);
        #1;
        check("rst_gnt", gnt_o, 0);
        check("rst_cyc", s_cyc_o, 0);
        check("rst_stb", s_stb_o, 0);
        check("rst_ack", m_ack_o, 0);
        check("rst_err", m_err_o, 0);
        idle_all();
        @(negedge wbm_clk);
        wbm_rst = 1'b1;
        model_reset();

        // Both masters request continuously; slave acks one cycle after stb
        m_cyc_i = '1; m_stb_i = '1;
        nack = 0;
        for (int n = 0; n < 12; n++) begin
            s_ack_i = (owner >= 0 && age >= 1);
            #1;
            if (m_ack_o != '0) begin
                check("rr_order", m_ack_o, (nack % 2 == 0) ? 2'b01 : 2'b10);
                nack++;
            end
            tick();
        end
        check("rr_ack_count", nack, 4);
        idle_all();
        tick();

        // Master 1 read of 0x40
        adr_a[1] = 32'h40; m_we_i[1] = 1'b0;
        m_cyc_i = 2'b10; m_stb_i = 2'b10;
        tick();
        s_dat_i = 32'hDEADBEEF; s_ack_i = 1'b1;
        #1;
        check("rd_dat", m_dat_o, 32'hDEADBEEF);
        check("rd_ack", m_ack_o, 2'b10);
        check("rd_adr", s_adr_o, 32'h40);
        tick();
        idle_all();
        tick();

        // Master 0 aborts after 2 BUSY cycles; master 1 pending
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        tick();
        tick();
        tick();
        m_cyc_i = 2'b10; m_stb_i = 2'b10;
        #1;
        check("abort_ack", m_ack_o, 0);
        check("abort_err", m_err_o, 0);
        tick();
        #1;
        check("abort_idle_gnt", gnt_o, 0);
        check("abort_idle_cyc", s_cyc_o, 0);
        tick();
        s_ack_i = 1'b1;
        #1;
        check("abort_next_gnt", gnt_o, 2'b10);
        tick();
        idle_all();
        tick();

        // Timeout: slave never acks
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        tick();
        stb_cnt = 0;
        for (int n = 0; n < TO; n++) begin
            #1;
            if (s_stb_o) stb_cnt++;
            tick();
        end
        check("to_stb_cycles", stb_cnt, TO);
        #1;
        check("to_err", m_err_o, 2'b01);
        check("to_cyc", s_cyc_o, 0);
        idle_all();
        tick();
        s_ack_i = 1'b1;
        #1;
        check("late_ack", m_ack_o, 0);
        tick();
        idle_all();
        tick();

        // Ack on the last permitted BUSY cycle
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        tick();
        for (int n = 0; n < TO - 1; n++) tick();
        s_ack_i = 1'b1;
        #1;
        check("edge_ack", m_ack_o, 2'b01);
        check("edge_err", m_err_o, 0);
        tick();
        idle_all();
        #1;
        check("edge_no_err", m_err_o, 0);
        tick();

        // Reset mid-BUSY
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        tick();
        tick();
        s_ack_i = 1'b1;
        #2;
        wbm_rst = 1'b0;
        #1;
        check("mid_rst_cyc", s_cyc_o, 0);
        check("mid_rst_gnt", gnt_o, 0);
        check("mid_rst_ack", m_ack_o, 0);
        check("mid_rst_err", m_err_o, 0);
        model_reset();
        s_ack_i = 1'b0;
        @(negedge wbm_clk);
        @(negedge wbm_clk);
        wbm_rst = 1'b1;
        tick();
        #1;
        check("post_rst_gnt", gnt_o, 2'b01);
        tick();
        idle_all();
        tick();
        tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NM; i++) begin
                if (m_cyc_i[i]) m_cyc_i[i] = ($urandom_range(0, 9) != 0);
                else            m_cyc_i[i] = ($urandom_range(0, 1) == 1);
                m_stb_i[i] = m_cyc_i[i] & ($urandom_range(0, 9) < 8);
                adr_a[i]   = $urandom;
                dat_a[i]   = $urandom;
                sel_a[i]   = 4'($urandom);
                m_we_i[i]  = 1'($urandom);
            end
            s_ack_i = ($urandom_range(0, 9) < 3);
            s_dat_i = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/peripheral_msi_arb_rr_wb.md
PERIPHERAL_MSI_ARB_RR_WB -- requirements
Module: peripheral_msi_arb_rr_wb

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; NM, default 2, number of masters (2..8); TIMEOUT, default 256, max BUSY cycles before error (>=2).
REQ-002 Ports SHALL be (name direction width meaning):
- wbm_clk  in  1  single clock; all logic on its rising edge.
- wbm_rst  in  1  asynchronous, active-low reset.
- m_adr_i  in  NM*AW  master addresses; master i at [i*AW +: AW].
- m_dat_i  in  NM*32  master write data.
- m_sel_i  in  NM*4  master byte selects.
- m_we_i  in  NM  master write enables.
- m_cyc_i  in  NM  master cycle.
- m_stb_i  in  NM  master strobe.
- m_dat_o  out  32  read data, broadcast to all masters.
- m_ack_o  out  NM  per-master acknowledge.
- m_err_o  out  NM  per-master timeout error.
- s_adr_o  out  AW  slave address (to CDC master port).
- s_dat_o  out  32  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- gnt_o  out  NM  one-hot current grant, all-zero when idle.

Function
REQ-003 Request i SHALL be m_cyc_i[i] & m_stb_i[i].
REQ-004 State machine SHALL have states IDLE, BUSY, ERR.
REQ-005 IDLE: if any request, SHALL register grant index g, chosen round-robin searching from (last+1) mod NM upward with wrap; next state BUSY; else stay IDLE.
REQ-006 BUSY: s_cyc_o = s_stb_o = 1; s_adr/dat/sel/we_o SHALL be combinational mux of master g inputs.
REQ-007 BUSY with s_ack_i=1: m_ack_o[g]=1 same cycle (combinational), last<=g, next state IDLE.
REQ-008 BUSY with m_cyc_i[g]=0 (master abort, no ack): SHALL return to IDLE with last<=g, no ack/err issued.
REQ-009 Simultaneous ack and abort in same cycle: ack SHALL take precedence (m_ack_o[g]=1).
REQ-010 Counter SHALL clear on entering BUSY and increment each BUSY cycle; in BUSY cycle TIMEOUT-1 without s_ack_i, next state ERR.
REQ-011 Ack in cycle TIMEOUT-1 SHALL be honoured as normal ack (no error).
REQ-012 ERR (exactly one cycle): s_cyc_o=s_stb_o=0, m_err_o[g]=1, last<=g, next state IDLE.
REQ-013 s_ack_i in IDLE or ERR SHALL be discarded; no m_ack_o bit asserted.
REQ-014 m_ack_o and m_err_o SHALL be zero for every master other than g, and zero outside BUSY/ERR respectively.
REQ-015 m_dat_o SHALL equal s_dat_i at all times.
REQ-016 gnt_o SHALL be one-hot of g in BUSY and ERR, zero in IDLE.
REQ-017 Minimum request-to-s_stb_o latency SHALL be 1 cycle; back-to-back transfers SHALL insert exactly one IDLE cycle.
REQ-018 Counter width SHALL be clog2(TIMEOUT+1) bits; counter SHALL never wrap.

Reset
REQ-019 On wbm_rst=0 (asynchronous): state IDLE, counter 0, g=0, last=NM-1 (master 0 highest priority first).
REQ-020 During reset s_cyc_o, s_stb_o, m_ack_o, m_err_o, gnt_o SHALL be 0; reset mid-BUSY SHALL drop s_cyc_o immediately with no ack/err.
REQ-021 Reset release SHALL be synchronous to wbm_clk by the integrating level; block leaves reset on first edge with wbm_rst=1.

Verification
REQ-022 NM=2; after reset both masters request continuously, slave acks 1 cycle after stb -> grants alternate 0,1,0,1; each m_ack_o pulse 1 cycle.
REQ-023 Master 1 reads adr 0x40, slave returns s_dat_i=0xDEADBEEF with ack -> m_dat_o=0xDEADBEEF, m_ack_o=2'b10 same cycle, s_adr_o=0x40 while BUSY.
REQ-024 TIMEOUT=4, slave never acks -> s_stb_o high exactly 4 cycles, then m_err_o[g]=1 one cycle, s_cyc_o=0; late ack next cycle -> m_ack_o=0.
REQ-025 TIMEOUT=4, ack on 4th BUSY cycle -> m_ack_o[g]=1, m_err_o stays 0.
REQ-026 Master 0 drops m_cyc_i after 2 BUSY cycles -> IDLE next cycle, no ack/err, master 1 pending request granted next.
REQ-027 Assert wbm_rst=0 mid-BUSY -> s_cyc_o, gnt_o 0 immediately; after release master 0 wins simultaneous request.
